// File: rtl/div_pkg.sv
// Constants and state encoding shared by the divider datapath, its controller
// and the BCD result converter.
package div_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_D = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        FIN    = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every scratch nibble >= 5, then shift
// {scratch, shift} left by one so the shift MSB enters the scratch LSB.
module bcd_dabble_step #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic [4*D-1:0] scratch,
    input  logic [W-1:0]   shift,
    output logic [4*D-1:0] scratch_next,
    output logic [W-1:0]   shift_next
);

    logic [4*D-1:0]   adj;
    logic [4*D+W-1:0] shifted;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < D; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // The top scratch bit drops out; 10^D > 2^W - 1 guarantees it is always zero.
    assign shifted = {adj, shift} << 1;
    assign {scratch_next, shift_next} = shifted;

endmodule

// File: rtl/div_result_bcd.sv
// Converts the divider quotient and remainder to packed BCD, time-sharing one
// double-dabble step (quotient pass, then remainder pass), with a done pulse.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W:0]     Qbus,
    input  logic [W:0]     Rbus,
    output logic [4*D-1:0] q_bcd,
    output logic [4*D-1:0] r_bcd,
    output logic           busy,
    output logic           done,
    output logic           range_err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    state_t         state, next_state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   shift_reg, hold_reg;
    logic [4*D-1:0] scratch, q_tmp;
    logic           err_hold;
    logic [4*D-1:0] step_scratch;
    logic [W-1:0]   step_shift;
    logic           last_iter;

    assign last_iter = (cnt == '0);

    bcd_dabble_step #(.W(W), .D(D)) u_step (
        .scratch      (scratch),
        .shift        (shift_reg),
        .scratch_next (step_scratch),
        .shift_next   (step_shift)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = CONV_Q;
            CONV_Q:  if (last_iter) next_state = CONV_R;
            CONV_R:  if (last_iter) next_state = FIN;
            FIN:                    next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // busy/done are registered from the next-state decode to keep outputs glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == CONV_R) && last_iter;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            scratch   <= '0;
            q_tmp     <= '0;
            err_hold  <= 1'b0;
            q_bcd     <= '0;
            r_bcd     <= '0;
            range_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shift_reg <= Qbus[W-1:0];
                    hold_reg  <= Rbus[W-1:0];
                    err_hold  <= Qbus[W] | Rbus[W];
                    scratch   <= '0;
                    cnt       <= CNT_LOAD;
                end
                CONV_Q: if (last_iter) begin
                    q_tmp     <= step_scratch;
                    shift_reg <= hold_reg;
                    scratch   <= '0;
                    cnt       <= CNT_LOAD;
                end else begin
                    scratch   <= step_scratch;
                    shift_reg <= step_shift;
                    cnt       <= cnt - CW'(1);
                end
                CONV_R: if (last_iter) begin
                    q_bcd     <= q_tmp;
                    r_bcd     <= step_scratch;
                    range_err <= err_hold;
                end else begin
                    scratch   <= step_scratch;
                    shift_reg <= step_shift;
                    cnt       <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: vector table plus hand-written sequences
// for reset, busy-time start pulses, input changes after capture and abort.
module tb_div_result_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  Qbus = '0;
    logic [8:0]  Rbus = '0;
    logic [11:0] q_bcd, r_bcd;
    logic        busy, done, range_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    div_result_bcd #(.W(8), .D(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Qbus      (Qbus),
        .Rbus      (Rbus),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [8:0]  q;
        logic [8:0]  r;
        logic [11:0] exp_q;
        logic [11:0] exp_r;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive a start pulse (sampled at edge E) and return the edge count to done.
    task automatic conv(input logic [8:0] q, input logic [8:0] r, output int lat);
        Qbus  = q;
        Rbus  = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_at_E", busy, 1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int dc;

        vecs[0] = '{9'd28,  9'd4,   12'h028, 12'h004, 1'b0};
        vecs[1] = '{9'd255, 9'd0,   12'h255, 12'h000, 1'b0};
        vecs[2] = '{9'd0,   9'd99,  12'h000, 12'h099, 1'b0};
        vecs[3] = '{9'd123, 9'd45,  12'h123, 12'h045, 1'b0};
        vecs[4] = '{9'h105, 9'd3,   12'h005, 12'h003, 1'b1};
        vecs[5] = '{9'd64,  9'h1FF, 12'h064, 12'h255, 1'b1};
        vecs[6] = '{9'd199, 9'd6,   12'h199, 12'h006, 1'b0};

        // Reset held with start asserted
        Qbus = 9'd28; Rbus = 9'd4; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_bcd", q_bcd, 0);
        chk("rst_r_bcd", r_bcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_range_err", range_err, 0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);

        // Table-driven conversions
        foreach (vecs[i]) begin
            dc = done_cnt;
            conv(vecs[i].q, vecs[i].r, lat);
            chk($sformatf("v%0d_latency", i), lat, 16);
            chk($sformatf("v%0d_q_bcd", i), q_bcd, vecs[i].exp_q);
            chk($sformatf("v%0d_r_bcd", i), r_bcd, vecs[i].exp_r);
            chk($sformatf("v%0d_range_err", i), range_err, vecs[i].exp_err);
            chk($sformatf("v%0d_busy_fin", i), busy, 1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_clear", i), done, 0);
            chk($sformatf("v%0d_busy_clear", i), busy, 0);
            chk($sformatf("v%0d_done_pulses", i), done_cnt - dc, 1);
            chk($sformatf("v%0d_q_hold", i), q_bcd, vecs[i].exp_q);
        end

        // Start pulses at E+5 and E+16 ignored; Qbus changed right after capture
        dc = done_cnt;
        Qbus = 9'd28; Rbus = 9'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        Qbus  = 9'd7;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 5 || k == 16) start = 1'b0;
            if (k == 4 || k == 15) begin
                Qbus = 9'd50 + 9'(k);
                Rbus = 9'd60;
                start = 1'b1;
            end
            if (k < 16) chk($sformatf("busy_seq_done_k%0d", k), done, 0);
            if (k == 16) begin
                chk("busy_seq_done_E16", done, 1);
                chk("busy_seq_q_bcd", q_bcd, 12'h028);
                chk("busy_seq_r_bcd", r_bcd, 12'h004);
            end
            if (k == 17) begin
                chk("busy_seq_busy_E17", busy, 0);
                chk("busy_seq_done_E17", done, 0);
            end
        end
        chk("busy_seq_single_done", done_cnt - dc, 1);
        chk("busy_seq_q_final", q_bcd, 12'h028);

        // Abort with rst at E+10
        Qbus = 9'd255; Rbus = 9'd99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_q_bcd", q_bcd, 0);
        chk("abort_r_bcd", r_bcd, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc, 0);
        chk("abort_busy_idle", busy, 0);
        chk("abort_q_still0", q_bcd, 0);

        // Normal conversion after abort
        conv(9'd87, 9'd13, lat);
        chk("after_abort_latency", lat, 16);
        chk("after_abort_q_bcd", q_bcd, 12'h087);
        chk("after_abort_r_bcd", r_bcd, 12'h013);
        chk("after_abort_range_err", range_err, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
